// File: rtl/rf_pkg.sv
// Shared types and constants for the register file with scoreboard.
// Imported by the busy tracker and the top.
package rf_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);

    typedef logic [XLEN_DEFAULT-1:0] word_t;
    typedef logic [AW_DEFAULT-1:0]   ridx_t;

    // Hard-wired zero register
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/rf_busy_tracker.sv
// Per-register pending-write flags.
// Flush beats issue, issue beats writeback clear.
module rf_busy_tracker
    import rf_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            we,
    input  logic [AW-1:0]   wR,
    input  logic            flush,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_next;
    logic            do_set;
    logic            do_clr;

    assign do_set = iss_valid && (iss_rd != AW'(ZERO_REG));
    assign do_clr = we && (wR != AW'(ZERO_REG));

    // Next busy vector: clear then set so a same-index issue stays pending
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (do_clr) begin
                busy_next[wR] = 1'b0;
            end
            if (do_set) begin
                busy_next[iss_rd] = 1'b1;
            end
        end
    end

    // Busy vector register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with write-first bypass, busy scoreboard
// and the decode-stage operand-B select.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rR1,
    input  logic [AW-1:0]   rR2,
    output logic [XLEN-1:0] rD1,
    output logic [XLEN-1:0] rD2,
    output logic            rbusy1,
    output logic            rbusy2,
    input  logic            we,
    input  logic [AW-1:0]   wR,
    input  logic [XLEN-1:0] wD,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    input  logic            op_B_sel,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] op_A,
    output logic [XLEN-1:0] op_B
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic            wr_ok;
    logic            hit1;
    logic            hit2;

    assign wr_ok = we && (wR != AW'(ZERO_REG));
    assign hit1  = wr_ok && (wR == rR1);
    assign hit2  = wr_ok && (wR == rR2);

    rf_busy_tracker #(
        .NREG (NREG),
        .AW   (AW)
    ) u_busy (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .wR        (wR),
        .flush     (flush),
        .busy      (busy)
    );

    // Storage array; index 0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wR] <= wD;
        end
    end

    // Read ports with write-first bypass and x0 forced to zero
    always_comb begin
        rD1 = regs[rR1];
        rD2 = regs[rR2];
        if (hit1) rD1 = wD;
        if (hit2) rD2 = wD;
        if (rR1 == AW'(ZERO_REG)) rD1 = '0;
        if (rR2 == AW'(ZERO_REG)) rD2 = '0;
    end

    // Busy flags, masked when the data arrives through the bypass
    always_comb begin
        rbusy1 = busy[rR1] && !hit1;
        rbusy2 = busy[rR2] && !hit2;
    end

    // ALU operand select
    always_comb begin
        op_A = rD1;
        op_B = op_B_sel ? rD2 : imm;
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed plus random checks of rf_scoreboard
// against an array-based reference model.
module tb_rf_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rR1, rR2, wR, iss_rd;
    logic [XLEN-1:0] rD1, rD2, wD, imm, op_A, op_B;
    logic            rbusy1, rbusy2, we, iss_valid, flush, op_B_sel;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] m_reg  [NREG];
    bit              m_busy [NREG];

    rf_scoreboard #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk       (clk),
        .rst       (rst),
        .rR1       (rR1),
        .rR2       (rR2),
        .rD1       (rD1),
        .rD2       (rD2),
        .rbusy1    (rbusy1),
        .rbusy2    (rbusy2),
        .we        (we),
        .wR        (wR),
        .wD        (wD),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .op_B_sel  (op_B_sel),
        .imm       (imm),
        .op_A      (op_A),
        .op_B      (op_B)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] e_rd(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
        if (we && wR == idx) return wD;
        return m_reg[idx];
    endfunction

    function automatic logic e_busy(input logic [AW-1:0] idx);
        if (idx == 0) return 1'b0;
        if (we && wR == idx) return 1'b0;
        return m_busy[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rD1"}, rD1, e_rd(rR1));
        chk({tag, ".rD2"}, rD2, e_rd(rR2));
        chk({tag, ".rbusy1"}, {31'b0, rbusy1}, {31'b0, e_busy(rR1)});
        chk({tag, ".rbusy2"}, {31'b0, rbusy2}, {31'b0, e_busy(rR2)});
        chk({tag, ".op_A"}, op_A, e_rd(rR1));
        chk({tag, ".op_B"}, op_B, op_B_sel ? e_rd(rR2) : imm);
    endtask

    // Advance one edge, applying the architectural rules to the model
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (we && wR != 0) m_reg[wR] = wD;
            if (flush) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            end else begin
                if (we && wR != 0) m_busy[wR] = 1'b0;
                if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        we = 0; iss_valid = 0; flush = 0;
        wR = 0; wD = 0; iss_rd = 0;
    endtask

    initial begin
        rst = 1; idle();
        rR1 = 0; rR2 = 0; op_B_sel = 0; imm = 32'h0;
        model_clear();
        #2;
        for (int i = 0; i < NREG; i++) begin
            rR1 = AW'(i); rR2 = AW'(NREG - 1 - i); #1;
            chk("rst.rD1", rD1, 32'h0);
            chk("rst.rbusy1", {31'b0, rbusy1}, 32'h0);
            chk("rst.rD2", rD2, 32'h0);
        end
        op_B_sel = 0; imm = 32'h55; #1;
        chk("rst.op_B_imm", op_B, 32'h55);
        @(negedge clk); rst = 0;
        tick();

        we = 1; wR = 0; wD = 32'hDEAD_BEEF; rR1 = 0; #1;
        chk("x0.bypass", rD1, 32'h0);
        tick(); idle(); #1;
        chk("x0.after", rD1, 32'h0);

        we = 1; wR = 5; wD = 32'h1234_5678; rR1 = 5; #1;
        chk("wr.bypass", rD1, 32'h1234_5678);
        check_all("wr.same");
        tick(); idle(); #1;
        chk("wr.array", rD1, 32'h1234_5678);

        iss_valid = 1; iss_rd = 7; rR2 = 7; #1;
        chk("sb.not_yet", {31'b0, rbusy2}, 32'h0);
        tick(); idle(); #1;
        chk("sb.busy", {31'b0, rbusy2}, 32'h1);
        we = 1; wR = 7; wD = 9; #1;
        chk("sb.mask", {31'b0, rbusy2}, 32'h0);
        chk("sb.byp", rD2, 32'h9);
        tick(); idle(); #1;
        chk("sb.cleared", {31'b0, rbusy2}, 32'h0);

        iss_valid = 1; iss_rd = 3; tick();
        iss_valid = 1; iss_rd = 3; we = 1; wR = 3; wD = 42;
        tick(); idle(); rR2 = 3; #1;
        chk("iw.busy", {31'b0, rbusy2}, 32'h1);
        chk("iw.data", rD2, 32'd42);
        check_all("iw");

        iss_valid = 1;
        iss_rd = 4; tick();
        iss_rd = 6; tick();
        iss_rd = 9; tick();
        rR1 = 6; #1;
        chk("fl.pre", {31'b0, rbusy1}, 32'h1);
        flush = 1; iss_rd = 10; we = 1; wR = 4; wD = 77;
        tick(); idle(); #1;
        rR1 = 4; #1;
        chk("fl.data", rD1, 32'd77);
        chk("fl.b4", {31'b0, rbusy1}, 32'h0);
        rR2 = 6;  #1; chk("fl.b6",  {31'b0, rbusy2}, 32'h0);
        rR2 = 9;  #1; chk("fl.b9",  {31'b0, rbusy2}, 32'h0);
        rR2 = 10; #1; chk("fl.b10", {31'b0, rbusy2}, 32'h0);
        rR2 = 3;  #1; chk("fl.b3",  {31'b0, rbusy2}, 32'h0);

        we = 1; wR = 8; wD = 32'h10; tick(); idle();
        rR2 = 8; op_B_sel = 1; #1;
        chk("mux.reg", op_B, 32'h10);
        op_B_sel = 0; imm = 32'hFFFF_FFFC; #1;
        chk("mux.imm", op_B, 32'hFFFF_FFFC);

        for (int n = 0; n < 400; n++) begin
            rR1       = AW'($urandom_range(0, NREG - 1));
            rR2       = AW'($urandom_range(0, NREG - 1));
            we        = ($urandom_range(0, 1) == 1);
            wR        = AW'($urandom_range(0, NREG - 1));
            wD        = $urandom;
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_rd    = AW'($urandom_range(0, NREG - 1));
            flush     = ($urandom_range(0, 15) == 0);
            op_B_sel  = ($urandom_range(0, 1) == 1);
            imm       = $urandom;
            if ($urandom_range(0, 3) == 0) wR = rR1;
            if ($urandom_range(0, 3) == 0) iss_rd = wR;
            #1;
            check_all("rnd");
            tick();
        end

        idle(); iss_valid = 1; iss_rd = 11; tick();
        idle(); we = 1; wR = 12; wD = 32'h66; tick();
        idle(); rR1 = 11; rR2 = 12; op_B_sel = 1;
        #3; rst = 1; #1;
        model_clear();
        chk("mrst.rD1", rD1, 32'h0);
        chk("mrst.rD2", rD2, 32'h0);
        chk("mrst.busy1", {31'b0, rbusy1}, 32'h0);
        chk("mrst.op_B", op_B, 32'h0);
        rR1 = 13; rR2 = 13;
        we = 1; wR = 11; wD = 32'h55;
        tick(); idle();
        @(negedge clk); rst = 0;
        rR1 = 11; rR2 = 12; #1;
        chk("mrst.drop", rD1, 32'h0);
        chk("mrst.lost", {31'b0, rbusy1}, 32'h0);
        check_all("mrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
